// File: rtl/alu_pkg.sv
// Shared definitions for the ALU request sequencer: opcodes, FSM states, default width.
package alu_pkg;

    localparam int ALU_WIDTH = 8;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_OR    = 3'b011;
    localparam logic [2:0] OP_XOR   = 3'b100;
    localparam logic [2:0] OP_SHL   = 3'b101;
    localparam logic [2:0] OP_SHR   = 3'b110;
    localparam logic [2:0] OP_PASSB = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } seq_state_t;

endpackage

// File: rtl/alu_seq_timer.sv
// Settle counter: loads a start value, counts down once per enabled cycle, flags zero.
module alu_seq_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic       done
);

    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= 4'd0;
        else        cnt_q <= cnt_d;
    end

    assign done = (cnt_q == 4'd0);

endmodule

// File: rtl/alu_seq_ctrl.sv
// Request sequencer in front of the ALU result mux: launches operands/select, samples mux_o after
// SETTLE cycles and holds result + flags for downstream. Optional accumulator feedback: ALU_SEQ_ACC_EN.
module alu_seq_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH  = ALU_WIDTH,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic [2:0]       sel,
    input  logic [WIDTH-1:0] mux_o,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_zero,
    output logic             res_neg,
    output logic             res_par
`ifdef ALU_SEQ_ACC_EN
    ,
    input  logic             req_acc
`endif
);

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE - 1);

    seq_state_t       state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
    logic [2:0]       sel_q, sel_d;
    logic             res_valid_q, res_valid_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic             res_zero_q, res_zero_d;
    logic             res_neg_q, res_neg_d;
    logic             res_par_q, res_par_d;
    logic [WIDTH-1:0] a_src;
    logic             accept, capture, tmr_done;

`ifdef ALU_SEQ_ACC_EN
    logic [WIDTH-1:0] acc_q, acc_d;

    always_comb begin
        acc_d = acc_q;
        if (capture) acc_d = mux_o;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc_q <= '0;
        else        acc_q <= acc_d;
    end

    assign a_src = req_acc ? acc_q : req_a;
`else
    assign a_src = req_a;
`endif

    assign req_ready = (state_q == IDLE) || ((state_q == HOLD) && res_ready);
    assign accept    = req_valid && req_ready;
    assign capture   = (state_q == WAIT) && tmr_done;

    alu_seq_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .load_val (SETTLE_LD),
        .dec      (state_q == WAIT),
        .done     (tmr_done)
    );

    always_comb begin
        state_d     = state_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        sel_d       = sel_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_zero_d  = res_zero_q;
        res_neg_d   = res_neg_q;
        res_par_d   = res_par_q;

        case (state_q)
            IDLE:    if (req_valid) state_d = WAIT;
            WAIT:    if (tmr_done) state_d = HOLD;
            HOLD:    if (res_ready) state_d = req_valid ? WAIT : IDLE;
            default: state_d = IDLE;
        endcase

        if (accept) begin
            op_a_d = a_src;
            op_b_d = req_b;
            sel_d  = req_op;
        end

        // Flags come from the sampled mux value itself, so they always match res_data.
        if (capture) begin
            res_data_d  = mux_o;
            res_zero_d  = (mux_o == '0);
            res_neg_d   = mux_o[WIDTH-1];
            res_par_d   = ^mux_o;
            res_valid_d = 1'b1;
        end

        if ((state_q == HOLD) && res_ready) res_valid_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_a_q      <= '0;
            op_b_q      <= '0;
            sel_q       <= 3'b000;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_zero_q  <= 1'b1;
            res_neg_q   <= 1'b0;
            res_par_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            sel_q       <= sel_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_zero_q  <= res_zero_d;
            res_neg_q   <= res_neg_d;
            res_par_q   <= res_par_d;
        end
    end

    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign sel       = sel_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_zero  = res_zero_q;
    assign res_neg   = res_neg_q;
    assign res_par   = res_par_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: one instance at SETTLE=1, one at SETTLE=3, modelled ALU mux.
module tb_alu_seq_ctrl;
    import alu_pkg::*;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // instance 1: SETTLE=1
    logic         rv1 = 0, rr1, rsv1, rsr1 = 0, z1, n1, p1, acc1 = 0;
    logic [2:0]   op1 = 0, sel1;
    logic [W-1:0] a1 = 0, b1 = 0, oa1, ob1, mux1, rd1;
    // instance 3: SETTLE=3
    logic         rv3 = 0, rr3, rsv3, rsr3 = 0, z3, n3, p3, acc3 = 0;
    logic [2:0]   op3 = 0, sel3;
    logic [W-1:0] a3 = 0, b3 = 0, oa3, ob3, mux3, rd3;
    logic         ovr3 = 0;
    logic [W-1:0] ovv3 = 0;

    function automatic logic [W-1:0] alu_f(input logic [2:0] s, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        case (s)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SHL:  return a << b[2:0];
            OP_SHR:  return a >> b[2:0];
            default: return b;
        endcase
    endfunction

    assign mux1 = alu_f(sel1, oa1, ob1);
    assign mux3 = ovr3 ? ovv3 : alu_f(sel3, oa3, ob3);

    alu_seq_ctrl #(.WIDTH(W), .SETTLE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv1), .req_ready(rr1), .req_op(op1),
        .req_a(a1), .req_b(b1), .op_a(oa1), .op_b(ob1), .sel(sel1), .mux_o(mux1),
        .res_valid(rsv1), .res_ready(rsr1), .res_data(rd1), .res_zero(z1), .res_neg(n1),
        .res_par(p1)
`ifdef ALU_SEQ_ACC_EN
        , .req_acc(acc1)
`endif
    );

    alu_seq_ctrl #(.WIDTH(W), .SETTLE(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv3), .req_ready(rr3), .req_op(op3),
        .req_a(a3), .req_b(b3), .op_a(oa3), .op_b(ob3), .sel(sel3), .mux_o(mux3),
        .res_valid(rsv3), .res_ready(rsr3), .res_data(rd3), .res_zero(z3), .res_neg(n3),
        .res_par(p3)
`ifdef ALU_SEQ_ACC_EN
        , .req_acc(acc3)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present a request on instance 1 for one edge (called at posedge+1).
    task automatic acc_req1(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        rv1 = 1; op1 = op; a1 = a; b1 = b;
        cyc();
        rv1 = 0;
    endtask

    task automatic acc_req3(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        rv3 = 1; op3 = op; a3 = a; b3 = b;
        cyc();
        rv3 = 0;
    endtask

    task automatic drain1(input string tag);
        rsr1 = 1;
        cyc();
        rsr1 = 0;
        chk({tag, "_drain_valid"}, rsv1, 0);
        chk({tag, "_drain_ready"}, rr1, 1);
    endtask

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", rsv1, 0);
        chk("rst_ready", rr1, 1);
        chk("rst_sel", sel1, 0);
        chk("rst_opa", oa1, 0);
        chk("rst_opb", ob1, 0);
        chk("rst_data", rd1, 0);
        chk("rst_zero", z1, 1);
        chk("rst_neg", n1, 0);
        chk("rst_par", p1, 0);
        @(negedge clk) rst_n = 1;
        cyc();

        // basic ADD, SETTLE=1
        acc_req1(OP_ADD, 8'h12, 8'h34);
        chk("add_sel", sel1, 3'b000);
        chk("add_opa", oa1, 8'h12);
        chk("add_opb", ob1, 8'h34);
        chk("add_valid_early", rsv1, 0);
        chk("add_ready_wait", rr1, 0);
        cyc();
        chk("add_valid", rsv1, 1);
        chk("add_data", rd1, 8'h46);
        chk("add_zero", z1, 0);
        chk("add_neg", n1, 0);
        chk("add_par", p1, 1);
        chk("add_ready_hold", rr1, 0);
        drain1("add");

        // zero flag via SUB
        acc_req1(OP_SUB, 8'h05, 8'h05);
        cyc();
        chk("sub_valid", rsv1, 1);
        chk("sub_data", rd1, 8'h00);
        chk("sub_zero", z1, 1);
        chk("sub_par", p1, 0);
        chk("sub_neg", n1, 0);
        drain1("sub");

        // negative/parity via PASSB, then backpressure with a pending XOR
        acc_req1(OP_PASSB, 8'h13, 8'h80);
        cyc();
        chk("passb_data", rd1, 8'h80);
        chk("passb_neg", n1, 1);
        chk("passb_par", p1, 1);
        chk("passb_zero", z1, 0);
        rv1 = 1; op1 = OP_XOR; a1 = 8'h0F; b1 = 8'hF0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("bp_valid", rsv1, 1);
            chk("bp_data", rd1, 8'h80);
            chk("bp_ready", rr1, 0);
            chk("bp_sel", sel1, OP_PASSB);
        end
        rsr1 = 1;
        #1;
        chk("b2b_ready_comb", rr1, 1);
        cyc();
        rv1 = 0; rsr1 = 0;
        chk("b2b_valid_drop", rsv1, 0);
        chk("b2b_sel", sel1, OP_XOR);
        chk("b2b_opa", oa1, 8'h0F);
        chk("b2b_ready_wait", rr1, 0);
        cyc();
        chk("b2b_valid", rsv1, 1);
        chk("b2b_data", rd1, 8'hFF);
        chk("b2b_par", p1, 0);
        chk("b2b_neg", n1, 1);
        drain1("b2b");

        // settle timing, SETTLE=3: mux_o changes two cycles after accept
        ovr3 = 1; ovv3 = 8'hFF;
        acc_req3(OP_ADD, 8'h01, 8'h02);
        chk("st_sel", sel3, OP_ADD);
        chk("st_opa", oa3, 8'h01);
        chk("st_valid0", rsv3, 0);
        cyc();
        chk("st_valid1", rsv3, 0);
        cyc();
        chk("st_valid2", rsv3, 0);
        ovv3 = 8'hAA;
        cyc();
        chk("st_valid3", rsv3, 1);
        chk("st_data", rd3, 8'hAA);
        chk("st_par", p3, 0);
        chk("st_neg", n3, 1);
        rsr3 = 1;
        cyc();
        rsr3 = 0; ovr3 = 0;
        chk("st_drain", rsv3, 0);

        // reset while in WAIT drops the operation
        acc_req3(OP_OR, 8'h21, 8'h42);
        chk("rw_sel_pre", sel3, OP_OR);
        cyc();
        rst_n = 0;
        #1;
        chk("rw_valid", rsv3, 0);
        chk("rw_sel", sel3, 0);
        chk("rw_opa", oa3, 0);
        chk("rw_ready", rr3, 1);
        @(posedge clk);
        @(negedge clk) rst_n = 1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("rw_no_result", rsv3, 0);
        end
        acc_req3(OP_AND, 8'hF0, 8'h3C);
        cyc();
        cyc();
        chk("rw_next_early", rsv3, 0);
        cyc();
        chk("rw_next_valid", rsv3, 1);
        chk("rw_next_data", rd3, 8'h30);
        chk("rw_next_par", p3, 0);
        rsr3 = 1;
        cyc();
        rsr3 = 0;

`ifdef ALU_SEQ_ACC_EN
        acc_req1(OP_ADD, 8'h10, 8'h01);
        cyc();
        chk("acc_add_data", rd1, 8'h11);
        drain1("acc_add");
        acc1 = 1;
        acc_req1(OP_OR, 8'h99, 8'h40);
        acc1 = 0;
        chk("acc_opa", oa1, 8'h11);
        cyc();
        chk("acc_or_data", rd1, 8'h51);
        drain1("acc_or");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
